// File: rtl/mod_counter.sv
// Up/down modulo counter with programmable modulus, wrap/saturate mode,
// terminal-count flag, one-cycle wrap pulse and sticky overflow flag.
module mod_counter #(
  parameter int unsigned     WIDTH    = 2,
  parameter longint unsigned MODULO   = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 1..32");
  end
  if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
    $error("mod_counter: MODULO must be in 2..2**WIDTH");
  end

  // Modulus held at WIDTH+1 bits so MODULO == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   ModExt   = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   TopExt   = ModExt - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULO - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot;

  assign at_top = ({1'b0, count_q} == TopExt);
  assign at_bot = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (rst || clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = ({1'b0, load_val} >= ModExt) ? MaxCount : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : '0;
        end else begin
          // Not at the top, so count_q < MODULO-1 and the add cannot overflow.
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : MaxCount;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
    ovf_q   <= ovf_d;
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign tc    = up_dn ? at_top : at_bot;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations share one stimulus stream and are
// checked every cycle against an integer model, plus hand-computed expectations.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clr, load;
  logic [1:0] load_val;

  logic [1:0] cnt    [3];
  logic       tc_w   [3];
  logic       wrap_w [3];
  logic       ovf_w  [3];

  int errors = 0;
  int checks = 0;

  // Index 0: MODULO=4 wrap, 1: MODULO=3 wrap, 2: MODULO=4 saturate.
  int mod_tab [3] = '{4, 3, 4};
  bit sat_tab [3] = '{1'b0, 1'b0, 1'b1};
  int m_cnt   [3];
  int m_wrap  [3];
  int m_ovf   [3];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(2), .MODULO(4), .SATURATE(1'b0)) u_m4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt[0]), .tc(tc_w[0]), .wrap(wrap_w[0]), .ovf(ovf_w[0])
  );
  mod_counter #(.WIDTH(2), .MODULO(3), .SATURATE(1'b0)) u_m3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt[1]), .tc(tc_w[1]), .wrap(wrap_w[1]), .ovf(ovf_w[1])
  );
  mod_counter #(.WIDTH(2), .MODULO(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt[2]), .tc(tc_w[2]), .wrap(wrap_w[2]), .ovf(ovf_w[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Step every configuration by the rules, using the inputs seen at this edge.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int nxt;
      if (rst || clr) begin
        m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i]  = (int'(load_val) >= mod_tab[i]) ? mod_tab[i] - 1 : int'(load_val);
        m_wrap[i] = 0;
      end else if (en) begin
        nxt = m_cnt[i] + (up_dn ? 1 : -1);
        if (nxt < 0 || nxt >= mod_tab[i]) begin
          m_wrap[i] = 1; m_ovf[i] = 1;
          if (!sat_tab[i]) m_cnt[i] = (nxt + mod_tab[i]) % mod_tab[i];
        end else begin
          m_cnt[i] = nxt; m_wrap[i] = 0;
        end
      end else begin
        m_wrap[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int exp_tc;
      exp_tc = up_dn ? int'(m_cnt[i] == mod_tab[i] - 1) : int'(m_cnt[i] == 0);
      chk($sformatf("model count[%0d]", i), int'(cnt[i]), m_cnt[i]);
      chk($sformatf("model wrap[%0d]", i), int'(wrap_w[i]), m_wrap[i]);
      chk($sformatf("model ovf[%0d]", i), int'(ovf_w[i]), m_ovf[i]);
      chk($sformatf("model tc[%0d]", i), int'(tc_w[i]), exp_tc);
    end
  endtask

  // One clock: model steps at the edge, outputs compared at the falling edge;
  // the caller then changes inputs well away from the next rising edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic [1:0] lv,
                       input logic e, input logic u);
    rst = r; clr = c; load = l; load_val = lv; en = e; up_dn = u;
  endtask

  int exp_m3_dn   [6] = '{2, 1, 0, 2, 1, 0};
  int exp_m3_dn_w [6] = '{1, 0, 0, 1, 0, 0};
  int exp_sat_up  [6] = '{1, 2, 3, 3, 3, 3};
  int exp_sat_up_w[6] = '{0, 0, 0, 1, 1, 1};
  int exp_sat_dn  [4] = '{2, 1, 0, 0};
  int exp_sat_dn_w[4] = '{0, 0, 0, 1};
  int gate_en     [4] = '{1, 0, 0, 1};
  int gate_cnt    [4] = '{1, 1, 1, 2};

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end

    // Reset, then free-running up count at MODULO=4.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc();
    chk("reset count", int'(cnt[0]), 0);
    chk("reset wrap", int'(wrap_w[0]), 0);
    chk("reset ovf", int'(ovf_w[0]), 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk($sformatf("m4 up count step %0d", i), int'(cnt[0]), i % 4);
      chk($sformatf("m4 up wrap step %0d", i), int'(wrap_w[0]), int'(i % 4 == 0));
      chk($sformatf("m4 up ovf step %0d", i), int'(ovf_w[0]), int'(i >= 4));
      if (i == 3) chk("m4 tc at 3", int'(tc_w[0]), 1);
    end

    // Clear, then MODULO=3 down count from 0.
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    cyc();
    chk("clr count m3", int'(cnt[1]), 0);
    chk("clr ovf m3", int'(ovf_w[1]), 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("m3 down count %0d", k), int'(cnt[1]), exp_m3_dn[k]);
      chk($sformatf("m3 down wrap %0d", k), int'(wrap_w[1]), exp_m3_dn_w[k]);
      if (k == 2) chk("m3 tc at 0 down", int'(tc_w[1]), 1);
    end

    // Saturation: up six cycles, then down four.
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("sat up count %0d", k), int'(cnt[2]), exp_sat_up[k]);
      chk($sformatf("sat up wrap %0d", k), int'(wrap_w[2]), exp_sat_up_w[k]);
    end
    up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("sat down count %0d", k), int'(cnt[2]), exp_sat_dn[k]);
      chk($sformatf("sat down wrap %0d", k), int'(wrap_w[2]), exp_sat_dn_w[k]);
    end
    chk("sat ovf sticky", int'(ovf_w[2]), 1);

    // Load, clamp, load beats enable, clr beats load.
    drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    cyc();
    chk("load 2 m3", int'(cnt[1]), 2);
    load_val = 2'd3;
    cyc();
    chk("load 3 clamp m3", int'(cnt[1]), 2);
    chk("load 3 m4", int'(cnt[0]), 3);
    chk("load keeps ovf m3", int'(ovf_w[1]), 1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    cyc();
    chk("load over en m3", int'(cnt[1]), 1);
    chk("load over en wrap m4", int'(wrap_w[0]), 0);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    cyc();
    chk("clr over load m3", int'(cnt[1]), 0);
    chk("clr over load ovf m3", int'(ovf_w[1]), 0);

    // Reset mid-count overrides load and enable.
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) cyc();
    chk("m4 at 2 before rst", int'(cnt[0]), 2);
    chk("m4 ovf before rst", int'(ovf_w[0]), 1);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    cyc();
    chk("rst over load count", int'(cnt[0]), 0);
    chk("rst over load wrap", int'(wrap_w[0]), 0);
    chk("rst over load ovf", int'(ovf_w[0]), 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    cyc();
    chk("resume after rst", int'(cnt[0]), 1);

    // Direction change affects tc immediately.
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc();
    clr = 1'b0;
    #1;
    chk("tc up at 0", int'(tc_w[0]), 0);
    up_dn = 1'b0;
    #1;
    chk("tc down at 0", int'(tc_w[0]), 1);
    up_dn = 1'b1;

    // Enable gating.
    for (int k = 0; k < 4; k++) begin
      en = gate_en[k][0];
      cyc();
      chk($sformatf("gate count %0d", k), int'(cnt[0]), gate_cnt[k]);
      chk($sformatf("gate wrap %0d", k), int'(wrap_w[0]), 0);
      chk($sformatf("gate ovf %0d", k), int'(ovf_w[0]), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
